rob_rollback_walker: RTL and testbench

//  Consumes the recover/recover_ptr pair from the branch recovery stage and rolls the reorder

---
 rtl/rob_pkg.sv | 15 +
 rtl/rob_age_compare.sv | 22 ++
 rtl/rob_rollback_walker.sv | 139 +++++++++++++
 tb/tb_rob_rollback_walker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the ROB rollback walker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

    // Default ROB index width; DEPTH = 2**ROB_PTR_WIDTH.
    localparam int ROB_PTR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } walk_state_e;

endpackage : rob_pkg

// File: rtl/rob_age_compare.sv
// Age comparison of two ROB indices relative to the current head.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (ROB indices), head (oldest entry) -> a_older = age(a) < age(b).
module rob_age_compare #(
    parameter int PTR_WIDTH = 4
) (
    input  logic [PTR_WIDTH-1:0] a,
    input  logic [PTR_WIDTH-1:0] b,
    input  logic [PTR_WIDTH-1:0] head,
    output logic                 a_older
);

    // Subtraction wraps naturally at PTR_WIDTH bits, giving distance from head.
    logic [PTR_WIDTH-1:0] age_a;
    logic [PTR_WIDTH-1:0] age_b;

    assign age_a   = a - head;
    assign age_b   = b - head;
    assign a_older = (age_a < age_b);

endmodule : rob_age_compare

// File: rtl/rob_rollback_walker.sv
// Rolls the ROB back after a mispredict: squashes tail-1 down to branch+1, one per cycle, then restores tail.
// Latency: req at edge N -> first squash visible after N; K squashes -> tail restore visible after edge N+K.
// Backpressure: none accepted; holds dispatch_stall while walking or while a request is pending.
// Ports: clk, reset (sync, active-low), recover/recover_ptr request, rob_head_ptr/rob_tail_ptr ROB state;
//        squash_valid/squash_idx per-entry squash, tail_restore_valid/ptr restore pulse,
//        dispatch_stall, busy, squash_count (entries squashed by the last completed rollback).
module rob_rollback_walker
    import rob_pkg::*;
#(
    parameter int PTR_WIDTH = ROB_PTR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recover,
    input  logic [PTR_WIDTH-1:0] recover_ptr,
    input  logic [PTR_WIDTH-1:0] rob_head_ptr,
    input  logic [PTR_WIDTH-1:0] rob_tail_ptr,
    output logic                 squash_valid,
    output logic [PTR_WIDTH-1:0] squash_idx,
    output logic                 tail_restore_valid,
    output logic [PTR_WIDTH-1:0] tail_restore_ptr,
    output logic                 dispatch_stall,
    output logic                 busy,
    output logic [PTR_WIDTH:0]   squash_count
);

    walk_state_e          state_q;
    logic                 recover_q;
    logic                 pending_q;
    logic [PTR_WIDTH-1:0] pend_ptr_q;
    logic [PTR_WIDTH-1:0] stop_q;
    logic [PTR_WIDTH-1:0] cur_q;
    logic [PTR_WIDTH:0]   cnt_q;

    logic                 req;
    logic                 start;
    logic [PTR_WIDTH-1:0] start_ptr;
    logic [PTR_WIDTH-1:0] start_p1;
    logic [PTR_WIDTH-1:0] tail_m1;
    logic                 new_older;
    logic                 retarget;
    logic [PTR_WIDTH-1:0] stop_eff;
    logic [PTR_WIDTH-1:0] stop_eff_p1;
    logic [PTR_WIDTH-1:0] cur_m1;

    // Only a rising edge of the level request starts a rollback.
    assign req       = recover & ~recover_q;
    assign start     = req | pending_q;
    assign start_ptr = pending_q ? pend_ptr_q : recover_ptr;
    assign start_p1  = start_ptr + 1'b1;
    assign tail_m1   = rob_tail_ptr - 1'b1;
    assign cur_m1    = cur_q - 1'b1;

    rob_age_compare #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_age_compare (
        .a       (recover_ptr),
        .b       (stop_q),
        .head    (rob_head_ptr),
        .a_older (new_older)
    );

    // An older branch arriving mid-walk extends the walk; the new stop point
    // must already govern this cycle's termination test.
    assign retarget    = req & new_older;
    assign stop_eff    = retarget ? recover_ptr : stop_q;
    assign stop_eff_p1 = stop_eff + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q            <= ST_IDLE;
            recover_q          <= 1'b0;
            pending_q          <= 1'b0;
            pend_ptr_q         <= '0;
            stop_q             <= '0;
            cur_q              <= '0;
            cnt_q              <= '0;
            squash_valid       <= 1'b0;
            squash_idx         <= '0;
            tail_restore_valid <= 1'b0;
            tail_restore_ptr   <= '0;
            squash_count       <= '0;
        end else begin
            recover_q <= recover;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        stop_q    <= start_ptr;
                        cur_q     <= tail_m1;
                        cnt_q     <= '0;
                        pending_q <= 1'b0;
                        if (start_p1 == rob_tail_ptr) begin
                            // Branch is already the youngest entry: nothing to squash.
                            state_q            <= ST_DONE;
                            tail_restore_valid <= 1'b1;
                            tail_restore_ptr   <= start_p1;
                        end else begin
                            state_q      <= ST_WALK;
                            squash_valid <= 1'b1;
                            squash_idx   <= tail_m1;
                        end
                    end
                end
                ST_WALK: begin
                    cnt_q  <= cnt_q + 1'b1;
                    stop_q <= stop_eff;
                    if (cur_q == stop_eff_p1) begin
                        state_q            <= ST_DONE;
                        squash_valid       <= 1'b0;
                        squash_idx         <= '0;
                        tail_restore_valid <= 1'b1;
                        tail_restore_ptr   <= stop_eff_p1;
                    end else begin
                        cur_q      <= cur_m1;
                        squash_idx <= cur_m1;
                    end
                end
                ST_DONE: begin
                    state_q            <= ST_IDLE;
                    tail_restore_valid <= 1'b0;
                    tail_restore_ptr   <= '0;
                    squash_count       <= cnt_q;
                    // One-deep buffer for a request landing on the restore cycle.
                    if (req) begin
                        pending_q  <= 1'b1;
                        pend_ptr_q <= recover_ptr;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign dispatch_stall = (state_q != ST_IDLE) | pending_q;

endmodule : rob_rollback_walker

// File: tb/tb_rob_rollback_walker.sv
module tb_rob_rollback_walker;

    logic       clk;
    logic       reset;
    logic       recover;
    logic [3:0] recover_ptr;
    logic [3:0] rob_head_ptr;
    logic [3:0] rob_tail_ptr;
    logic       squash_valid;
    logic [3:0] squash_idx;
    logic       tail_restore_valid;
    logic [3:0] tail_restore_ptr;
    logic       dispatch_stall;
    logic       busy;
    logic [4:0] squash_count;

    int checks = 0;
    int errors = 0;

    rob_rollback_walker #(.PTR_WIDTH(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .recover            (recover),
        .recover_ptr        (recover_ptr),
        .rob_head_ptr       (rob_head_ptr),
        .rob_tail_ptr       (rob_tail_ptr),
        .squash_valid       (squash_valid),
        .squash_idx         (squash_idx),
        .tail_restore_valid (tail_restore_valid),
        .tail_restore_ptr   (tail_restore_ptr),
        .dispatch_stall     (dispatch_stall),
        .busy               (busy),
        .squash_count       (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  head;
        logic [3:0]  tail;
        logic [3:0]  ptr;
        int          nsq;
        logic [15:0] sq_list;   // expected squash indices, first in the top nibble
        logic [3:0]  restore;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{head: 4'd0,  tail: 4'd8, ptr: 4'd3,  nsq: 4, sq_list: 16'h7654, restore: 4'd4};
        vecs[1] = '{head: 4'd12, tail: 4'd2, ptr: 4'd14, nsq: 3, sq_list: 16'h10F0, restore: 4'd15};
        vecs[2] = '{head: 4'd0,  tail: 4'd6, ptr: 4'd5,  nsq: 0, sq_list: 16'h0000, restore: 4'd6};
        vecs[3] = '{head: 4'd5,  tail: 4'd5, ptr: 4'd4,  nsq: 0, sq_list: 16'h0000, restore: 4'd5};
        vecs[4] = '{head: 4'd3,  tail: 4'd0, ptr: 4'd15, nsq: 0, sq_list: 16'h0000, restore: 4'd0};
        vecs[5] = '{head: 4'd0,  tail: 4'd3, ptr: 4'd0,  nsq: 2, sq_list: 16'h2100, restore: 4'd1};

        reset = 1'b0;
        recover = 1'b0;
        recover_ptr = '0;
        rob_head_ptr = '0;
        rob_tail_ptr = '0;
        repeat (3) step();
        chk("rst_squash_valid", int'(squash_valid), 0);
        chk("rst_squash_idx", int'(squash_idx), 0);
        chk("rst_restore_valid", int'(tail_restore_valid), 0);
        chk("rst_restore_ptr", int'(tail_restore_ptr), 0);
        chk("rst_stall", int'(dispatch_stall), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(squash_count), 0);
        reset = 1'b1;
        step();

        // Table-driven single rollbacks.
        foreach (vecs[v]) begin
            rob_head_ptr = vecs[v].head;
            rob_tail_ptr = vecs[v].tail;
            recover_ptr  = vecs[v].ptr;
            recover      = 1'b1;
            step();
            recover = 1'b0;
            for (int k = 0; k < vecs[v].nsq; k++) begin
                chk($sformatf("v%0d_sq%0d_valid", v, k), int'(squash_valid), 1);
                chk($sformatf("v%0d_sq%0d_idx", v, k), int'(squash_idx), int'(vecs[v].sq_list[15-4*k -: 4]));
                chk($sformatf("v%0d_sq%0d_stall", v, k), int'(dispatch_stall), 1);
                step();
            end
            chk($sformatf("v%0d_restore_valid", v), int'(tail_restore_valid), 1);
            chk($sformatf("v%0d_restore_ptr", v), int'(tail_restore_ptr), int'(vecs[v].restore));
            chk($sformatf("v%0d_done_sqv", v), int'(squash_valid), 0);
            chk($sformatf("v%0d_done_busy", v), int'(busy), 1);
            step();
            chk($sformatf("v%0d_idle_restore", v), int'(tail_restore_valid), 0);
            chk($sformatf("v%0d_idle_busy", v), int'(busy), 0);
            chk($sformatf("v%0d_count", v), int'(squash_count), vecs[v].nsq);
            step();
        end

        // Older branch arrives mid-walk: walk extends down to 3.
        rob_head_ptr = 4'd0; rob_tail_ptr = 4'd12; recover_ptr = 4'd5; recover = 1'b1;
        step();
        chk("rt_idx11", int'(squash_idx), 11);
        recover = 1'b0;
        step();
        chk("rt_idx10", int'(squash_idx), 10);
        step();
        chk("rt_idx9", int'(squash_idx), 9);
        recover = 1'b1; recover_ptr = 4'd2;
        step();
        for (int i = 8; i >= 3; i--) begin
            chk($sformatf("rt_idx%0d", i), int'(squash_idx), i);
            chk($sformatf("rt_sqv%0d", i), int'(squash_valid), 1);
            step();
        end
        chk("rt_restore_valid", int'(tail_restore_valid), 1);
        chk("rt_restore_ptr", int'(tail_restore_ptr), 3);
        step();
        chk("rt_count", int'(squash_count), 9);
        recover = 1'b0;
        step();

        // Younger branch arrives mid-walk: ignored, restore stays at 6.
        rob_head_ptr = 4'd0; rob_tail_ptr = 4'd12; recover_ptr = 4'd5; recover = 1'b1;
        step();
        chk("ig_idx11", int'(squash_idx), 11);
        recover = 1'b0;
        step();
        chk("ig_idx10", int'(squash_idx), 10);
        recover = 1'b1; recover_ptr = 4'd9;
        step();
        for (int i = 9; i >= 6; i--) begin
            chk($sformatf("ig_idx%0d", i), int'(squash_idx), i);
            step();
        end
        chk("ig_restore_valid", int'(tail_restore_valid), 1);
        chk("ig_restore_ptr", int'(tail_restore_ptr), 6);
        step();
        chk("ig_count", int'(squash_count), 6);
        recover = 1'b0;
        step();

        // Recover held high for many cycles: exactly one rollback.
        begin
            int nsv = 0;
            int ntr = 0;
            rob_head_ptr = 4'd0; rob_tail_ptr = 4'd6; recover_ptr = 4'd3; recover = 1'b1;
            repeat (10) begin
                step();
                if (squash_valid) nsv++;
                if (tail_restore_valid) ntr++;
            end
            chk("hold_squashes", nsv, 2);
            chk("hold_restores", ntr, 1);
            chk("hold_count", int'(squash_count), 2);
            recover = 1'b0;
            step();
        end

        // Request on the restore cycle is buffered and serviced afterwards.
        rob_head_ptr = 4'd0; rob_tail_ptr = 4'd6; recover_ptr = 4'd4; recover = 1'b1;
        step();
        chk("pd_idx5", int'(squash_idx), 5);
        recover = 1'b0;
        step();
        chk("pd_restore_ptr", int'(tail_restore_ptr), 5);
        rob_tail_ptr = 4'd5; recover_ptr = 4'd2; recover = 1'b1;
        step();
        chk("pd_pend_busy", int'(busy), 0);
        chk("pd_pend_stall", int'(dispatch_stall), 1);
        chk("pd_pend_count", int'(squash_count), 1);
        recover = 1'b0;
        step();
        chk("pd_idx4", int'(squash_idx), 4);
        chk("pd_sqv4", int'(squash_valid), 1);
        step();
        chk("pd_idx3", int'(squash_idx), 3);
        step();
        chk("pd_restore2_valid", int'(tail_restore_valid), 1);
        chk("pd_restore2_ptr", int'(tail_restore_ptr), 3);
        step();
        chk("pd_count2", int'(squash_count), 2);
        chk("pd_stall_clear", int'(dispatch_stall), 0);
        step();

        // Reset in the middle of a walk.
        rob_head_ptr = 4'd0; rob_tail_ptr = 4'd8; recover_ptr = 4'd3; recover = 1'b1;
        step();
        chk("mr_idx7", int'(squash_idx), 7);
        step();
        chk("mr_idx6", int'(squash_idx), 6);
        reset = 1'b0;
        recover = 1'b0;
        step();
        chk("mr_sqv", int'(squash_valid), 0);
        chk("mr_idx", int'(squash_idx), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_stall", int'(dispatch_stall), 0);
        chk("mr_restore", int'(tail_restore_valid), 0);
        chk("mr_count", int'(squash_count), 0);
        reset = 1'b1;
        step();
        chk("mr_no_restore", int'(tail_restore_valid), 0);
        recover = 1'b1;
        step();
        recover = 1'b0;
        for (int i = 7; i >= 4; i--) begin
            chk($sformatf("mr2_idx%0d", i), int'(squash_idx), i);
            step();
        end
        chk("mr2_restore_valid", int'(tail_restore_valid), 1);
        chk("mr2_restore_ptr", int'(tail_restore_ptr), 4);
        step();
        chk("mr2_count", int'(squash_count), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rob_rollback_walker
